// File: rtl/risc16_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : risc16_bus_pkg
//  Purpose : Shared definitions for the risc16ba bus responder: MMIO window
//            byte offsets, STATUS register bit positions and the halt-FSM
//            state type.
//  Revision: 1.0  initial release
// ============================================================================
package risc16_bus_pkg;

    // Byte offsets inside the MMIO window (word aligned).
    localparam logic [2:0] IO_LED_OFS    = 3'd0;
    localparam logic [2:0] IO_LED2_OFS   = 3'd2;
    localparam logic [2:0] IO_TIMER_OFS  = 3'd4;
    localparam logic [2:0] IO_STATUS_OFS = 3'd6;

    // STATUS register bit positions.
    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_OVF_BIT  = 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

endpackage : risc16_bus_pkg
`default_nettype wire

// File: rtl/risc16_mmio_regs.sv
`default_nettype none
// ============================================================================
//  Module  : risc16_mmio_regs
//  Purpose : MMIO register file for the responder: three 8-bit LED registers,
//            the free-running cycle timer with sticky overflow, and the
//            STATUS read value, plus the MMIO read multiplexer.
//  Ports   : clk, rst (sync, active-low)
//            wr_en      store strobe already qualified by window hit and
//                       halt state
//            we0/we1    byte-lane enables (high/low byte)
//            ofs        word index inside the window (byte offset [2:1])
//            wdata      store data
//            tick       timer advance enable (state != HALTED)
//            done       halt flag reflected in STATUS
//            rdata      MMIO read data
//            led        {led_2, led_1, led_0}
//  Config  : RISC16_MMIO_TIMER_EN builds the timer and the ovf flag; without
//            it TIMER and STATUS.ovf read as zero and no flops exist.
//  Revision: 1.0  initial release
// ============================================================================
module risc16_mmio_regs
    import risc16_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  ofs,
    input  logic [15:0] wdata,
    input  logic        tick,
    input  logic        done,
    output logic [15:0] rdata,
    output logic [23:0] led
);

    logic [7:0]  r_led_0;
    logic [7:0]  r_led_1;
    logic [7:0]  r_led_2;
    logic        w_sel_led;
    logic        w_sel_led2;
    logic        w_sel_timer;
    logic        w_sel_status;
    logic [15:0] w_timer;
    logic        w_ovf;
    logic [15:0] w_status;

    assign w_sel_led    = wr_en && (ofs == IO_LED_OFS[2:1]);
    assign w_sel_led2   = wr_en && (ofs == IO_LED2_OFS[2:1]);
    assign w_sel_timer  = wr_en && (ofs == IO_TIMER_OFS[2:1]);
    assign w_sel_status = wr_en && (ofs == IO_STATUS_OFS[2:1]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_led_0 <= 8'h00;
            r_led_1 <= 8'h00;
            r_led_2 <= 8'h00;
        end else begin
            if (w_sel_led && we0)  r_led_1 <= wdata[15:8];
            if (w_sel_led && we1)  r_led_0 <= wdata[7:0];
            // LED2 has only a low byte; the high lane is ignored.
            if (w_sel_led2 && we1) r_led_2 <= wdata[7:0];
        end
    end

`ifdef RISC16_MMIO_TIMER_EN
    logic [15:0] r_timer;
    logic        r_ovf;
    logic        w_timer_clr;
    logic        w_timer_wrap;

    assign w_timer_clr  = w_sel_timer && (we0 || we1);
    // A clear in the same cycle as ffff->0000 suppresses the wrap.
    assign w_timer_wrap = tick && !w_timer_clr && (r_timer == 16'hffff);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer <= 16'h0000;
            r_ovf   <= 1'b0;
        end else begin
            if (w_timer_clr)
                r_timer <= 16'h0000;
            else if (tick)
                r_timer <= r_timer + 16'h0001;

            // Setting the sticky flag beats a simultaneous software clear.
            if (w_timer_wrap)
                r_ovf <= 1'b1;
            else if (w_sel_status && we1 && wdata[STATUS_OVF_BIT])
                r_ovf <= 1'b0;
        end
    end

    assign w_timer = r_timer;
    assign w_ovf   = r_ovf;
`else
    logic w_unused_tick;

    assign w_unused_tick = tick ^ w_sel_timer ^ w_sel_status;
    assign w_timer       = 16'h0000;
    assign w_ovf         = 1'b0;
`endif

    always_comb begin
        w_status                  = 16'h0000;
        w_status[STATUS_DONE_BIT] = done;
        w_status[STATUS_OVF_BIT]  = w_ovf;
    end

    always_comb begin
        rdata = 16'h0000;
        case (ofs)
            IO_LED_OFS[2:1]:    rdata = {r_led_1, r_led_0};
            IO_LED2_OFS[2:1]:   rdata = {8'h00, r_led_2};
            IO_TIMER_OFS[2:1]:  rdata = w_timer;
            IO_STATUS_OFS[2:1]: rdata = w_status;
            default:            rdata = 16'h0000;
        endcase
    end

    assign led = {r_led_2, r_led_1, r_led_0};

endmodule : risc16_mmio_regs
`default_nettype wire

// File: rtl/risc16_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : risc16_mem_responder
//  Purpose : Synthesizable responder for both risc16ba buses. Serves
//            instruction fetches and data loads/stores from a byte-lane RAM,
//            decodes an 8-byte MMIO window (LEDs, cycle timer, status), and
//            detects the program-end fetch, drains in-flight stores for
//            DRAIN_CYC cycles and then raises done.
//  Ports   : clk, rst (sync, active-low)
//            iaddr/ioe/idin          instruction port (RAM only)
//            daddr/ddout/doe/dwe0/1  data port (RAM or MMIO)
//            ddin                    load data
//            led                     {led_2, led_1, led_0}
//            done                    high once HALTED
//  Config  : RISC16_MMIO_TIMER_EN enables the TIMER register and STATUS.ovf.
//  Notes   : Reads are combinational. The RAM has no reset and no load
//            logic; INIT_FILE names the byte image (big-endian word order)
//            that the FPGA build preloads into the mem_hi/mem_lo lanes.
//  Revision: 1.0  initial release
// ============================================================================
module risc16_mem_responder
    import risc16_bus_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter              INIT_FILE = "risc16.mem",
    parameter logic [15:0] IO_BASE   = 16'h0200,
    parameter logic [15:0] HALT_PC   = 16'h001c,
    parameter int          DRAIN_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] iaddr,
    input  logic        ioe,
    output logic [15:0] idin,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    input  logic        doe,
    input  logic        dwe0,
    input  logic        dwe1,
    output logic [15:0] ddin,
    output logic [23:0] led,
    output logic        done
);

    localparam int    c_WORDS = 2 ** (ADDR_W - 1);
    localparam int    c_CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam string c_unused_init_file = INIT_FILE;

    // Even byte addresses live in mem_hi, odd ones in mem_lo.
    logic [7:0] mem_hi [0:c_WORDS-1];
    logic [7:0] mem_lo [0:c_WORDS-1];

    halt_state_t         r_state;
    halt_state_t         w_state_nxt;
    logic [c_CNT_W-1:0]  r_drain_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    logic [ADDR_W-2:0]   w_iidx;
    logic [ADDR_W-2:0]   w_didx;
    logic [15:0]         w_io_ofs;
    logic                w_io_hit;
    logic                w_st_en;
    logic [15:0]         w_mmio_rdata;
    logic                w_unused_daddr_lsb;

    assign w_iidx = iaddr[ADDR_W-1:1];
    assign w_didx = daddr[ADDR_W-1:1];
    // Lane choice comes only from dwe0/dwe1, so the data address LSB is unused.
    assign w_unused_daddr_lsb = daddr[0];

    assign w_io_ofs = {daddr[15:1], 1'b0} - IO_BASE;
    assign w_io_hit = (w_io_ofs < 16'd8);
    assign w_st_en  = (r_state != HALTED);

    // ------------------------------------------------------------------
    // RAM lanes: write on posedge, read combinationally (old data on a
    // same-cycle store/load to one address).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_st_en && !w_io_hit && dwe0) mem_hi[w_didx] <= ddout[15:8];
        if (w_st_en && !w_io_hit && dwe1) mem_lo[w_didx] <= ddout[7:0];
    end

    assign idin = ioe ? {mem_hi[w_iidx], mem_lo[w_iidx]} : 16'h0000;

    always_comb begin
        ddin = 16'h0000;
        if (doe)
            ddin = w_io_hit ? w_mmio_rdata : {mem_hi[w_didx], mem_lo[w_didx]};
    end

    risc16_mmio_regs u_mmio (
        .clk   (clk),
        .rst   (rst),
        .wr_en (w_st_en && w_io_hit),
        .we0   (dwe0),
        .we1   (dwe1),
        .ofs   (w_io_ofs[2:1]),
        .wdata (ddout),
        .tick  (w_st_en),
        .done  (done),
        .rdata (w_mmio_rdata),
        .led   (led)
    );

    // ------------------------------------------------------------------
    // Halt FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_drain_cnt;
        case (r_state)
            RUN: begin
                if (ioe && (iaddr == HALT_PC)) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = c_CNT_W'(DRAIN_CYC - 1);
                end
            end
            DRAIN: begin
                if (r_drain_cnt == '0)
                    w_state_nxt = HALTED;
                else
                    w_cnt_nxt = r_drain_cnt - 1'b1;
            end
            HALTED: w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    assign done = (r_state == HALTED);

endmodule : risc16_mem_responder
`default_nettype wire

// File: tb/tb_risc16_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_risc16_mem_responder
//  Purpose : Directed self-checking bench for risc16_mem_responder.
//  Revision: 1.0  initial release
// ============================================================================
module tb_risc16_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] iaddr;
    logic        ioe;
    logic [15:0] idin;
    logic [15:0] daddr;
    logic [15:0] ddout;
    logic        doe;
    logic        dwe0;
    logic        dwe1;
    logic [15:0] ddin;
    logic [23:0] led;
    logic        done;

    int checks = 0;
    int errors = 0;

    risc16_mem_responder dut (
        .clk   (clk),
        .rst   (rst),
        .iaddr (iaddr),
        .ioe   (ioe),
        .idin  (idin),
        .daddr (daddr),
        .ddout (ddout),
        .doe   (doe),
        .dwe0  (dwe0),
        .dwe1  (dwe1),
        .ddin  (ddin),
        .led   (led),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        ioe = 1'b0; iaddr = 16'h0000;
        doe = 1'b0; daddr = 16'h0000; ddout = 16'h0000;
        dwe0 = 1'b0; dwe1 = 1'b0;
    endtask

    // Apply one clock edge and return just after it.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d,
                         input logic w0, input logic w1);
        idle();
        daddr = a; ddout = d; dwe0 = w0; dwe1 = w1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        next();
        next();
        checks++; if (led !== 24'h0) begin errors++; $display("FAIL reset_led: got %h expected %h", led, 24'h0); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (idin !== 16'h0) begin errors++; $display("FAIL idin_ioe_low: got %h expected 0000", idin); end
        checks++; if (ddin !== 16'h0) begin errors++; $display("FAIL ddin_doe_low: got %h expected 0000", ddin); end
        doe = 1'b1; daddr = 16'h0206; #1;
        checks++; if (ddin !== 16'h0) begin errors++; $display("FAIL reset_status: got %h expected 0000", ddin); end
`ifdef RISC16_MMIO_TIMER_EN
        daddr = 16'h0204; #1;
        checks++; if (ddin !== 16'h0) begin errors++; $display("FAIL reset_timer: got %h expected 0000", ddin); end
`endif
        rst = 1'b1;
        idle();
    endtask

    task automatic test_ram_read();
        store(16'h0000, 16'h1234, 1'b1, 1'b1);
        next();
        idle(); ioe = 1'b1; iaddr = 16'h0000; doe = 1'b1; daddr = 16'h0001; #1;
        checks++; if (idin !== 16'h1234) begin errors++; $display("FAIL ram_idin: got %h expected 1234", idin); end
        checks++; if (ddin !== 16'h1234) begin errors++; $display("FAIL ram_ddin_odd: got %h expected 1234", ddin); end
    endtask

    task automatic test_lanes();
        store(16'hc000, 16'h1111, 1'b1, 1'b1);
        next();
        store(16'hc000, 16'habcd, 1'b1, 1'b0); doe = 1'b1; #1;
        checks++; if (ddin !== 16'h1111) begin errors++; $display("FAIL same_cycle_old: got %h expected 1111", ddin); end
        next();
        idle(); doe = 1'b1; daddr = 16'hc000; #1;
        checks++; if (ddin !== 16'hab11) begin errors++; $display("FAIL hi_lane_only: got %h expected ab11", ddin); end
        store(16'hc001, 16'h00ee, 1'b0, 1'b1);
        next();
        idle(); ioe = 1'b1; iaddr = 16'hc001; #1;
        checks++; if (idin !== 16'habee) begin errors++; $display("FAIL lo_lane_unaligned: got %h expected abee", idin); end
    endtask

    task automatic test_led();
        logic [15:0] base0;
        logic [15:0] base2;
        idle(); ioe = 1'b1; iaddr = 16'h0200; #1; base0 = idin;
        iaddr = 16'h0202; #1; base2 = idin;
        store(16'h0200, 16'h5a3c, 1'b1, 1'b1); next();
        store(16'h0202, 16'h0077, 1'b0, 1'b1); next();
        store(16'h0202, 16'hff00, 1'b1, 1'b0); next();
        idle(); #1;
        checks++; if (led !== 24'h775a3c) begin errors++; $display("FAIL led_value: got %h expected 775a3c", led); end
        doe = 1'b1; daddr = 16'h0201; #1;
        checks++; if (ddin !== 16'h5a3c) begin errors++; $display("FAIL led_read: got %h expected 5a3c", ddin); end
        daddr = 16'h0202; #1;
        checks++; if (ddin !== 16'h0077) begin errors++; $display("FAIL led2_read: got %h expected 0077", ddin); end
        ioe = 1'b1; iaddr = 16'h0200; #1;
        checks++; if (idin !== base0) begin errors++; $display("FAIL ram_200_kept: got %h expected %h", idin, base0); end
        iaddr = 16'h0202; #1;
        checks++; if (idin !== base2) begin errors++; $display("FAIL ram_202_kept: got %h expected %h", idin, base2); end
    endtask

    task automatic test_timer();
`ifdef RISC16_MMIO_TIMER_EN
        idle(); rst = 1'b0; next(); rst = 1'b1;
        repeat (65536) next();
        doe = 1'b1; daddr = 16'h0204; #1;
        checks++; if (ddin !== 16'h0000) begin errors++; $display("FAIL timer_wrap: got %h expected 0000", ddin); end
        daddr = 16'h0206; #1;
        checks++; if (ddin !== 16'h0002) begin errors++; $display("FAIL status_ovf: got %h expected 0002", ddin); end
        store(16'h0206, 16'h0002, 1'b0, 1'b1); next();
        idle(); doe = 1'b1; daddr = 16'h0206; #1;
        checks++; if (ddin !== 16'h0000) begin errors++; $display("FAIL ovf_clear: got %h expected 0000", ddin); end
        store(16'h0204, 16'h0000, 1'b1, 1'b0); next();
        idle(); doe = 1'b1; daddr = 16'h0204; #1;
        checks++; if (ddin !== 16'h0000) begin errors++; $display("FAIL timer_clear: got %h expected 0000", ddin); end
        repeat (5) next();
        checks++; if (ddin !== 16'h0005) begin errors++; $display("FAIL timer_count: got %h expected 0005", ddin); end
`else
        logic [15:0] base4;
        idle(); ioe = 1'b1; iaddr = 16'h0204; #1; base4 = idin;
        store(16'h0204, 16'hbeef, 1'b1, 1'b1); next();
        repeat (3) next();
        idle(); doe = 1'b1; daddr = 16'h0204; #1;
        checks++; if (ddin !== 16'h0000) begin errors++; $display("FAIL timer_absent: got %h expected 0000", ddin); end
        daddr = 16'h0206; #1;
        checks++; if (ddin !== 16'h0000) begin errors++; $display("FAIL status_no_ovf: got %h expected 0000", ddin); end
        ioe = 1'b1; iaddr = 16'h0204; #1;
        checks++; if (idin !== base4) begin errors++; $display("FAIL timer_store_dropped: got %h expected %h", idin, base4); end
`endif
    endtask

    task automatic test_halt();
        store(16'h0200, 16'h0102, 1'b1, 1'b1); next();
        store(16'h0202, 16'h0003, 1'b0, 1'b1); next();
        store(16'hc012, 16'h4444, 1'b1, 1'b1); next();
        store(16'hc010, 16'h0000, 1'b1, 1'b1); next();
        // cycle 0: program-end fetch, timer cleared in the same cycle
        store(16'h0204, 16'h0000, 1'b1, 1'b0); ioe = 1'b1; iaddr = 16'h001c; next();
        // cycle 1
        store(16'hc010, 16'haaaa, 1'b1, 1'b1); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL drain1_done: got %b expected 0", done); end
        next();
        // cycle 2
        idle(); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL drain2_done: got %b expected 0", done); end
        next();
        // cycle 3
        store(16'hc010, 16'h00bb, 1'b0, 1'b1); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL drain3_done: got %b expected 0", done); end
        next();
        // cycle 4: halted, this store must be dropped
        store(16'hc012, 16'h3333, 1'b1, 1'b1); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halted_done: got %b expected 1", done); end
        next();
        store(16'h0200, 16'hffff, 1'b1, 1'b1); next();
        idle(); doe = 1'b1;
`ifdef RISC16_MMIO_TIMER_EN
        daddr = 16'h0204; #1;
        checks++; if (ddin !== 16'h0003) begin errors++; $display("FAIL timer_frozen_a: got %h expected 0003", ddin); end
`endif
        daddr = 16'hc010; #1;
        checks++; if (ddin !== 16'haabb) begin errors++; $display("FAIL drain_stores: got %h expected aabb", ddin); end
        daddr = 16'hc012; #1;
        checks++; if (ddin !== 16'h4444) begin errors++; $display("FAIL halted_store: got %h expected 4444", ddin); end
        daddr = 16'h0206; #1;
        checks++; if (ddin !== 16'h0001) begin errors++; $display("FAIL status_done: got %h expected 0001", ddin); end
        checks++; if (led !== 24'h030102) begin errors++; $display("FAIL halted_led: got %h expected 030102", led); end
        repeat (4) next();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b expected 1", done); end
`ifdef RISC16_MMIO_TIMER_EN
        daddr = 16'h0204; #1;
        checks++; if (ddin !== 16'h0003) begin errors++; $display("FAIL timer_frozen_b: got %h expected 0003", ddin); end
`endif
    endtask

    task automatic test_reset_drain();
        idle(); rst = 1'b0; next(); rst = 1'b1;
        store(16'h0200, 16'h5555, 1'b1, 1'b1); next();
        idle(); ioe = 1'b1; iaddr = 16'h001c; next();
        store(16'hc020, 16'h7777, 1'b1, 1'b1); next();
        idle(); rst = 1'b0; next();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_drain_done: got %b expected 0", done); end
        checks++; if (led !== 24'h0) begin errors++; $display("FAIL rst_drain_led: got %h expected 000000", led); end
        rst = 1'b1;
        store(16'hc022, 16'h1357, 1'b1, 1'b1); next();
        idle(); repeat (4) next();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_after_rst: got %b expected 0", done); end
        doe = 1'b1; daddr = 16'hc020; #1;
        checks++; if (ddin !== 16'h7777) begin errors++; $display("FAIL ram_kept_c020: got %h expected 7777", ddin); end
        daddr = 16'hc010; #1;
        checks++; if (ddin !== 16'haabb) begin errors++; $display("FAIL ram_kept_c010: got %h expected aabb", ddin); end
        daddr = 16'hc022; #1;
        checks++; if (ddin !== 16'h1357) begin errors++; $display("FAIL store_after_rst: got %h expected 1357", ddin); end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_ram_read();
        test_lanes();
        test_led();
        test_timer();
        test_halt();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_risc16_mem_responder
`default_nettype wire
